// File: rtl/red_seq_pkg.sv
// Shared types and sizes for the RED (reduction add) sequencer.
package red_seq_pkg;

    localparam int NIB_W   = 4;
    localparam int DATA_W  = 16;
    localparam int N_STEPS = 7;

    typedef enum logic [3:0] {
        IDLE = 4'd0,
        L1_0 = 4'd1,
        L1_1 = 4'd2,
        L1_2 = 4'd3,
        L1_3 = 4'd4,
        L2_0 = 4'd5,
        L2_1 = 4'd6,
        L3   = 4'd7,
        FIN  = 4'd8
    } state_t;

endpackage

// File: rtl/adder_4bit_red.sv
// Nibble adder slice shared by every reduction step of the RED sequencer.
module adder_4bit_red
    import red_seq_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             cin,
    output logic [NIB_W-1:0] sum,
    output logic             cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{NIB_W{1'b0}}, cin};

endmodule

// File: rtl/red_seq_ctrl.sv
// Multi-cycle RED sequencer: seven additions through one shared nibble adder,
// carries collected in a 3-bit counter that supplies the upper result bits.
module red_seq_ctrl
    import red_seq_pkg::*;
#(
    parameter bit SEXT = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              flush,
    input  logic              stall,
    input  logic [DATA_W-1:0] rs,
    input  logic [DATA_W-1:0] rt,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rd
);

    state_t            state;
    logic [DATA_W-1:0] rs_q;
    logic [DATA_W-1:0] rt_q;
    logic [NIB_W-1:0]  p0, p1, p2, p3, q0, q1, s;
    logic [2:0]        cnt;
    logic [2:0]        cnt_next;
    logic [NIB_W-1:0]  a_op;
    logic [NIB_W-1:0]  b_op;
    logic [NIB_W-1:0]  sum;
    logic              cout;

    // Operand selection for the single adder, driven by the current step.
    always_comb begin
        a_op = '0;
        b_op = '0;
        case (state)
            L1_0:    begin a_op = rs_q[3:0];   b_op = rt_q[3:0];   end
            L1_1:    begin a_op = rs_q[7:4];   b_op = rt_q[7:4];   end
            L1_2:    begin a_op = rs_q[11:8];  b_op = rt_q[11:8];  end
            L1_3:    begin a_op = rs_q[15:12]; b_op = rt_q[15:12]; end
            L2_0:    begin a_op = p0;          b_op = p1;          end
            L2_1:    begin a_op = p2;          b_op = p3;          end
            L3:      begin a_op = q0;          b_op = q1;          end
            default: begin a_op = '0;          b_op = '0;          end
        endcase
    end

    adder_4bit_red u_adder (
        .a    (a_op),
        .b    (b_op),
        .cin  (1'b0),
        .sum  (sum),
        .cout (cout)
    );

    assign cnt_next = cnt + {2'b00, cout};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            rd    <= '0;
            rs_q  <= '0;
            rt_q  <= '0;
            p0    <= '0;
            p1    <= '0;
            p2    <= '0;
            p3    <= '0;
            q0    <= '0;
            q1    <= '0;
            s     <= '0;
            cnt   <= '0;
        end else if (flush) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            cnt   <= '0;
        end else if (stall) begin
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        rs_q  <= rs;
                        rt_q  <= rt;
                        cnt   <= '0;
                        state <= L1_0;
                        busy  <= 1'b1;
                    end
                end
                L1_0: begin p0 <= sum; cnt <= cnt_next; state <= L1_1; end
                L1_1: begin p1 <= sum; cnt <= cnt_next; state <= L1_2; end
                L1_2: begin p2 <= sum; cnt <= cnt_next; state <= L1_3; end
                L1_3: begin p3 <= sum; cnt <= cnt_next; state <= L2_0; end
                L2_0: begin q0 <= sum; cnt <= cnt_next; state <= L2_1; end
                L2_1: begin q1 <= sum; cnt <= cnt_next; state <= L3;   end
                L3:   begin s  <= sum; cnt <= cnt_next; state <= FIN;  end
                FIN: begin
                    // res[6] is cnt[2]; it is the sign bit for the extension.
                    rd    <= {{(DATA_W-7){SEXT & cnt[2]}}, cnt, s};
                    done  <= 1'b1;
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_red_seq_ctrl.sv
// Directed self-checking bench for red_seq_ctrl (SEXT=1 plus a SEXT=0 copy).
module tb_red_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic        stall = 1'b0;
    logic [15:0] rs = '0;
    logic [15:0] rt = '0;
    logic        busy, done;
    logic [15:0] rd;
    logic        busy_z, done_z;
    logic [15:0] rd_z;

    int checks = 0;
    int errors = 0;
    int lat;
    int done_seen;

    red_seq_ctrl #(.SEXT(1'b1)) dut (
        .clk(clk), .rst(rst), .start(start), .flush(flush), .stall(stall),
        .rs(rs), .rt(rt), .busy(busy), .done(done), .rd(rd)
    );

    red_seq_ctrl #(.SEXT(1'b0)) dut_z (
        .clk(clk), .rst(rst), .start(start), .flush(flush), .stall(stall),
        .rs(rs), .rt(rt), .busy(busy_z), .done(done_z), .rd(rd_z)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Presents operands with start for one accepting edge, then scrambles them.
    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b);
        start = 1'b1;
        rs = a;
        rt = b;
        tick();
        start = 1'b0;
        rs = ~a;
        rt = 16'h1234;
    endtask

    task automatic waitDone(output int n);
        n = 0;
        while (!done && n < 40) begin
            tick();
            n++;
        end
    endtask

    initial begin
        rst = 1'b1;
        #2;
        checkOutput("reset_busy", {31'b0, busy}, 32'd0);
        checkOutput("reset_done", {31'b0, done}, 32'd0);
        checkOutput("reset_rd", {16'b0, rd}, 32'h0000);
        tick();
        rst = 1'b0;
        tick();

        // T1
        applyStimulus(16'h1111, 16'h1111);
        checkOutput("t1_busy_rise", {31'b0, busy}, 32'd1);
        waitDone(lat);
        checkOutput("t1_latency", lat, 32'd8);
        checkOutput("t1_rd", {16'b0, rd}, 32'h0008);
        checkOutput("t1_busy_fall", {31'b0, busy}, 32'd0);
        tick();
        checkOutput("t1_done_pulse", {31'b0, done}, 32'd0);
        checkOutput("t1_rd_hold", {16'b0, rd}, 32'h0008);

        // T2
        applyStimulus(16'hFFFF, 16'hFFFF);
        waitDone(lat);
        checkOutput("t2_latency", lat, 32'd8);
        checkOutput("t2_rd_sext", {16'b0, rd}, 32'hFFF8);
        checkOutput("t2_rd_zext", {16'b0, rd_z}, 32'h0078);
        tick();

        // T3 followed by a start in the done cycle
        applyStimulus(16'h8888, 16'h8888);
        waitDone(lat);
        checkOutput("t3_rd", {16'b0, rd}, 32'hFFC0);
        applyStimulus(16'h0000, 16'h0000);
        checkOutput("t3_b2b_busy", {31'b0, busy}, 32'd1);
        waitDone(lat);
        checkOutput("t3_b2b_latency", lat, 32'd8);
        checkOutput("t3_b2b_rd", {16'b0, rd}, 32'h0000);
        tick();

        // T4: stall in L2_0 plus a start pulse while busy
        applyStimulus(16'hFFFF, 16'hFFFF);
        done_seen = 0;
        lat = 0;
        for (int i = 0; i < 4; i++) begin
            start = (i == 1);
            rs = 16'h0101;
            tick();
            lat++;
        end
        start = 1'b0;
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            lat++;
            if (done) done_seen++;
        end
        stall = 1'b0;
        checkOutput("t4_busy_in_stall", {31'b0, busy}, 32'd1);
        while (!done && lat < 40) begin
            tick();
            lat++;
        end
        checkOutput("t4_latency", lat, 32'd11);
        checkOutput("t4_rd", {16'b0, rd}, 32'hFFF8);
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done || busy) done_seen++;
        end
        checkOutput("t4_single_done", done_seen, 32'd0);

        // T5: flush during L3, then flush together with start in IDLE
        applyStimulus(16'hFFFF, 16'hFFFF);
        for (int i = 0; i < 6; i++) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checkOutput("t5_busy_flush", {31'b0, busy}, 32'd0);
        checkOutput("t5_rd_kept", {16'b0, rd}, 32'hFFF8);
        done_seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done) done_seen++;
        end
        checkOutput("t5_no_done", done_seen, 32'd0);
        flush = 1'b1;
        applyStimulus(16'h1111, 16'h1111);
        flush = 1'b0;
        checkOutput("t5_flush_drops_start", {31'b0, busy}, 32'd0);
        applyStimulus(16'h1111, 16'h1111);
        waitDone(lat);
        checkOutput("t5_t1_rd", {16'b0, rd}, 32'h0008);
        tick();

        // T6: async reset during L1_2
        applyStimulus(16'h8888, 16'h8888);
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        checkOutput("t6_busy_async", {31'b0, busy}, 32'd0);
        checkOutput("t6_rd_async", {16'b0, rd}, 32'h0000);
        checkOutput("t6_done_async", {31'b0, done}, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        applyStimulus(16'h8888, 16'h8888);
        waitDone(lat);
        checkOutput("t6_latency", lat, 32'd8);
        checkOutput("t6_rd", {16'b0, rd}, 32'hFFC0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
